// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the writeback, MUL/DIV, decode and register-file write-port
// signals that surround rf_wb_arbiter. The arbiter takes the slave view;
// the pipeline / MUL/DIV unit / register file side takes the master view.
interface rf_wb_arbiter_if;
   // Pipeline writeback request
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   // MUL/DIV result channel
   logic        md_valid;
   logic [4:0]  md_rd;
   logic [31:0] md_data;
   logic        md_ready;
   // MUL/DIV issue from decode
   logic        md_issue;
   logic [4:0]  md_issue_rd;
   // Decode hazard query
   logic [4:0]  dec_rs1;
   logic        dec_rs1_used;
   logic [4:0]  dec_rs2;
   logic        dec_rs2_used;
   logic [4:0]  dec_rd;
   logic        dec_rd_valid;
   logic        dec_is_md;
   logic        stall;
   logic        pipe_hold;
   // Register file write port
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic [2:0]  pending;

   modport slave (
      input  wb_valid, wb_rd, wb_data,
      input  md_valid, md_rd, md_data,
      output md_ready,
      input  md_issue, md_issue_rd,
      input  dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used,
      input  dec_rd, dec_rd_valid, dec_is_md,
      output stall, pipe_hold,
      output rf_we, rf_rd, rf_wdata, pending
   );

   modport master (
      output wb_valid, wb_rd, wb_data,
      output md_valid, md_rd, md_data,
      input  md_ready,
      output md_issue, md_issue_rd,
      output dec_rs1, dec_rs1_used, dec_rs2, dec_rs2_used,
      output dec_rd, dec_rd_valid, dec_is_md,
      input  stall, pipe_hold,
      input  rf_we, rf_rd, rf_wdata, pending
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the in-order WB stage and the
// multi-cycle MUL/DIV unit. Tracks registers with an outstanding MUL/DIV
// result, stalls decode on RAW/WAW/capacity hazards, and forces a one-cycle
// WB hold when a MUL/DIV result has been refused for STARVE_LIMIT cycles.
module rf_wb_arbiter #(
   parameter int MAX_PENDING  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic           clk,
   input logic           reset,
   rf_wb_arbiter_if.slave bus
);

   localparam int SCW = $clog2(STARVE_LIMIT + 1);
   typedef logic [SCW-1:0] scnt_t;

   logic [31:0] busy_q, busy_d;
   logic [2:0]  pending_q, pending_d;
   scnt_t       starve_q, starve_d;
   logic        hold_q, hold_d;
   logic        grant_wb, grant_md;

   // Write-port grant: WB wins unless a starvation hold is in force.
   always_comb begin
      grant_wb = 1'b0;
      grant_md = 1'b0;
      if (reset) begin
         if (hold_q) begin
            grant_md = bus.md_valid;
         end else if (bus.wb_valid) begin
            grant_wb = 1'b1;
         end else begin
            grant_md = bus.md_valid;
         end
      end
   end

   // Steer the granted source onto the write port; x0 is never written.
   always_comb begin
      bus.md_ready = grant_md;
      bus.rf_rd    = grant_wb ? bus.wb_rd   : bus.md_rd;
      bus.rf_wdata = grant_wb ? bus.wb_data : bus.md_data;
      bus.rf_we    = (grant_wb && (bus.wb_rd != 5'd0)) ||
                     (grant_md && (bus.md_rd != 5'd0));
   end

   // Decode hazard detection; no bypass from a result retiring this cycle.
   always_comb begin
      bus.stall = reset &&
                  ((bus.dec_rs1_used && busy_q[bus.dec_rs1]) ||
                   (bus.dec_rs2_used && busy_q[bus.dec_rs2]) ||
                   (bus.dec_rd_valid && busy_q[bus.dec_rd])  ||
                   (bus.dec_is_md && (pending_q == 3'(MAX_PENDING))));
      bus.pending   = pending_q;
      bus.pipe_hold = hold_q;
   end

   // Next-state of scoreboard, pending count and starvation counter.
   always_comb begin
      busy_d = busy_q;
      if (grant_md) begin
         busy_d[bus.md_rd] = 1'b0;
      end
      // A same-cycle issue to the retiring register must keep it busy.
      if (bus.md_issue) begin
         busy_d[bus.md_issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;

      pending_d = pending_q;
      case ({bus.md_issue, grant_md})
         2'b10:   pending_d = pending_q + 3'd1;
         2'b01:   pending_d = pending_q - 3'd1;
         default: pending_d = pending_q;
      endcase

      starve_d = starve_q;
      if (!bus.md_valid || grant_md) begin
         starve_d = '0;
      end else if (starve_q != scnt_t'(STARVE_LIMIT)) begin
         starve_d = starve_q + scnt_t'(1);
      end

      // Hold fires in the cycle right after the counter saturates.
      hold_d = !hold_q && (starve_d == scnt_t'(STARVE_LIMIT));
   end

   // State registers, cleared immediately on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q    <= '0;
         pending_q <= '0;
         starve_q  <= '0;
         hold_q    <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         pending_q <= pending_d;
         starve_q  <= starve_d;
         hold_q    <= hold_d;
      end
   end

   // Protocol checks for the surrounding pipeline and MUL/DIV unit.
   a_issue_no_stall : assert property (@(posedge clk) disable iff (!reset)
      bus.md_issue |-> !bus.stall);
   a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
      !(bus.md_issue && !grant_md && (pending_q == 3'(MAX_PENDING))));
   a_no_underflow : assert property (@(posedge clk) disable iff (!reset)
      !(grant_md && !bus.md_issue && (pending_q == 3'd0)));
   a_md_valid_held : assert property (@(posedge clk) disable iff (!reset)
      (bus.md_valid && !bus.md_ready) |=> bus.md_valid);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: each step drives inputs, queues the
// expected outputs for that cycle, and compares them at the falling edge.
module tb_rf_wb_arbiter;

   localparam int SIG_WE    = 0;
   localparam int SIG_RD    = 1;
   localparam int SIG_WDATA = 2;
   localparam int SIG_MDRDY = 3;
   localparam int SIG_STALL = 4;
   localparam int SIG_HOLD  = 5;
   localparam int SIG_PEND  = 6;

   typedef struct {
      string       tag;
      int          sig;
      logic [31:0] val;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;
   exp_t q[$];

   rf_wb_arbiter_if bus ();

   rf_wb_arbiter #(
      .MAX_PENDING  (2),
      .STARVE_LIMIT (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] observe(int sig);
      case (sig)
         SIG_WE:    return {31'd0, bus.rf_we};
         SIG_RD:    return {27'd0, bus.rf_rd};
         SIG_WDATA: return bus.rf_wdata;
         SIG_MDRDY: return {31'd0, bus.md_ready};
         SIG_STALL: return {31'd0, bus.stall};
         SIG_HOLD:  return {31'd0, bus.pipe_hold};
         default:   return {29'd0, bus.pending};
      endcase
   endfunction

   task automatic exp_push(string tag, int sig, logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = val;
      q.push_back(e);
   endtask

   task automatic idle();
      bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
      bus.md_valid = 0; bus.md_rd = 0; bus.md_data = 0;
      bus.md_issue = 0; bus.md_issue_rd = 0;
      bus.dec_rs1 = 0; bus.dec_rs1_used = 0;
      bus.dec_rs2 = 0; bus.dec_rs2_used = 0;
      bus.dec_rd = 0;  bus.dec_rd_valid = 0;
      bus.dec_is_md = 0;
   endtask

   // Compare queued expectations at the falling edge, then move to just
   // after the next rising edge for the following stimulus.
   task automatic step();
      exp_t        e;
      logic [31:0] o;
      @(negedge clk);
      while (q.size() > 0) begin
         e = q.pop_front();
         o = observe(e.sig);
         n_total++;
         assert (o === e.val) begin
            n_pass++;
         end else begin
            $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      #1;
      // Reset held with a WB request present
      reset = 1'b0;
      bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'hAA;
      exp_push("rst_we", SIG_WE, 0);
      exp_push("rst_mdrdy", SIG_MDRDY, 0);
      exp_push("rst_stall", SIG_STALL, 0);
      exp_push("rst_pend", SIG_PEND, 0);
      exp_push("rst_hold", SIG_HOLD, 0);
      step();
      reset = 1'b1;
      exp_push("rel_we", SIG_WE, 1);
      exp_push("rel_rd", SIG_RD, 5);
      exp_push("rel_wdata", SIG_WDATA, 32'hAA);
      step();

      // Priority: WB wins, MUL/DIV goes next cycle
      idle();
      bus.md_issue = 1; bus.md_issue_rd = 4;
      exp_push("pri_issue_stall", SIG_STALL, 0);
      step();
      idle();
      bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'h11;
      bus.md_valid = 1; bus.md_rd = 4; bus.md_data = 32'h22;
      exp_push("pri_rd_wb", SIG_RD, 3);
      exp_push("pri_wdata_wb", SIG_WDATA, 32'h11);
      exp_push("pri_mdrdy0", SIG_MDRDY, 0);
      exp_push("pri_pend1", SIG_PEND, 1);
      step();
      bus.wb_valid = 0;
      exp_push("pri_rd_md", SIG_RD, 4);
      exp_push("pri_wdata_md", SIG_WDATA, 32'h22);
      exp_push("pri_mdrdy1", SIG_MDRDY, 1);
      exp_push("pri_we_md", SIG_WE, 1);
      step();
      idle();
      exp_push("pri_pend0", SIG_PEND, 0);
      step();

      // Scoreboard RAW/WAW on x10
      bus.md_issue = 1; bus.md_issue_rd = 10;
      exp_push("sb_issue_stall", SIG_STALL, 0);
      step();
      idle();
      bus.dec_rs1 = 10; bus.dec_rs1_used = 1;
      exp_push("sb_rs1_stall", SIG_STALL, 1);
      exp_push("sb_pend1", SIG_PEND, 1);
      step();
      idle();
      bus.dec_rs1 = 10;
      exp_push("sb_rs1_unused", SIG_STALL, 0);
      step();
      idle();
      bus.dec_rs2 = 10; bus.dec_rs2_used = 1;
      exp_push("sb_rs2_stall", SIG_STALL, 1);
      step();
      idle();
      bus.dec_rd = 10; bus.dec_rd_valid = 1;
      exp_push("sb_waw_stall", SIG_STALL, 1);
      step();
      idle();
      bus.dec_rs1 = 10; bus.dec_rs1_used = 1;
      bus.md_valid = 1; bus.md_rd = 10; bus.md_data = 32'h33;
      exp_push("sb_nobypass", SIG_STALL, 1);
      exp_push("sb_acc_rdy", SIG_MDRDY, 1);
      exp_push("sb_acc_wdata", SIG_WDATA, 32'h33);
      step();
      bus.md_valid = 0;
      exp_push("sb_clear_stall", SIG_STALL, 0);
      exp_push("sb_pend0", SIG_PEND, 0);
      step();

      // Capacity limit
      idle();
      bus.md_issue = 1; bus.md_issue_rd = 6; bus.dec_is_md = 1;
      exp_push("cap_i6_stall", SIG_STALL, 0);
      step();
      bus.md_issue_rd = 7;
      exp_push("cap_i7_stall", SIG_STALL, 0);
      exp_push("cap_pend1", SIG_PEND, 1);
      step();
      bus.md_issue = 0;
      exp_push("cap_full_stall", SIG_STALL, 1);
      exp_push("cap_pend2", SIG_PEND, 2);
      step();
      bus.md_valid = 1; bus.md_rd = 6; bus.md_data = 32'h66;
      exp_push("cap_acc_rdy", SIG_MDRDY, 1);
      exp_push("cap_acc_stall", SIG_STALL, 1);
      step();
      bus.md_valid = 0;
      exp_push("cap_after_pend", SIG_PEND, 1);
      exp_push("cap_after_stall", SIG_STALL, 0);
      step();
      idle();
      bus.md_valid = 1; bus.md_rd = 7; bus.md_data = 32'h77;
      exp_push("cap_drain_rdy", SIG_MDRDY, 1);
      step();
      idle();
      exp_push("cap_drain_pend", SIG_PEND, 0);
      step();

      // Starvation: WB every cycle while a result waits on x9
      bus.md_issue = 1; bus.md_issue_rd = 9;
      step();
      idle();
      for (int k = 1; k <= 4; k++) begin
         bus.wb_valid = 1; bus.wb_rd = 5'(k + 1); bus.wb_data = 32'(k);
         bus.md_valid = 1; bus.md_rd = 9; bus.md_data = 32'h99;
         exp_push($sformatf("stv_refuse%0d_rdy", k), SIG_MDRDY, 0);
         exp_push($sformatf("stv_refuse%0d_hold", k), SIG_HOLD, 0);
         exp_push($sformatf("stv_refuse%0d_rd", k), SIG_RD, 32'(k + 1));
         step();
      end
      exp_push("stv_hold1", SIG_HOLD, 1);
      exp_push("stv_hold_rdy", SIG_MDRDY, 1);
      exp_push("stv_hold_rd", SIG_RD, 9);
      exp_push("stv_hold_wdata", SIG_WDATA, 32'h99);
      exp_push("stv_hold_we", SIG_WE, 1);
      step();
      bus.md_valid = 0; bus.wb_rd = 2;
      exp_push("stv_hold0", SIG_HOLD, 0);
      exp_push("stv_wb_back", SIG_RD, 2);
      exp_push("stv_pend0", SIG_PEND, 0);
      step();

      // MUL/DIV to x0
      idle();
      bus.md_issue = 1; bus.md_issue_rd = 0;
      step();
      idle();
      bus.dec_rs1 = 0; bus.dec_rs1_used = 1;
      exp_push("x0_no_busy", SIG_STALL, 0);
      exp_push("x0_pend1", SIG_PEND, 1);
      step();
      idle();
      bus.md_valid = 1; bus.md_rd = 0; bus.md_data = 32'h5;
      exp_push("x0_rdy", SIG_MDRDY, 1);
      exp_push("x0_we", SIG_WE, 0);
      step();
      idle();
      exp_push("x0_pend0", SIG_PEND, 0);
      step();

      // Asynchronous reset in the middle of an outstanding op
      bus.md_issue = 1; bus.md_issue_rd = 12;
      step();
      idle();
      bus.dec_rs1 = 12; bus.dec_rs1_used = 1;
      exp_push("mid_pre_stall", SIG_STALL, 1);
      step();
      #2;
      reset = 1'b0;
      exp_push("mid_rst_pend", SIG_PEND, 0);
      exp_push("mid_rst_stall", SIG_STALL, 0);
      step();
      reset = 1'b1;
      exp_push("mid_rel_stall", SIG_STALL, 0);
      exp_push("mid_rel_pend", SIG_PEND, 0);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline writeback and the multi-cycle RV32M MUL/DIV unit.
- Keeps a scoreboard of destination registers with an outstanding MUL/DIV result.
- Raises a decode stall on RAW/WAW hazards against those registers.
- Prevents MUL/DIV starvation by forcing a one-cycle pipeline hold.
- Sits between the WB stage, the MUL/DIV unit and the register file write port (clk, we, rd, indata).

Parameters:
- MAX_PENDING, 2, maximum outstanding MUL/DIV ops tracked (1..4).
- STARVE_LIMIT, 4, consecutive cycles a valid MUL/DIV result may wait before pipe_hold is forced (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wb_valid  in  1  pipeline writeback request.
- wb_rd  in  5  pipeline destination register.
- wb_data  in  32  pipeline writeback data.
- md_valid  in  1  MUL/DIV result valid.
- md_rd  in  5  MUL/DIV destination register.
- md_data  in  32  MUL/DIV result.
- md_ready  out  1  MUL/DIV result accepted this cycle.
- md_issue  in  1  MUL/DIV op issued from decode this cycle.
- md_issue_rd  in  5  destination of the issued op.
- dec_rs1  in  5  decode source register 1.
- dec_rs1_used  in  1  rs1 is read by the decoded instruction.
- dec_rs2  in  5  decode source register 2.
- dec_rs2_used  in  1  rs2 is read by the decoded instruction.
- dec_rd  in  5  decode destination register.
- dec_rd_valid  in  1  the decoded instruction writes rd.
- dec_is_md  in  1  the decoded instruction is MUL/DIV.
- stall  out  1  decode must hold this cycle.
- pipe_hold  out  1  pipeline must freeze its WB stage this cycle.
- rf_we  out  1  register file write enable.
- rf_rd  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- pending  out  3  count of outstanding MUL/DIV ops.

Behaviour:
- Reset (reset=0, asynchronous): busy[31:0]=0, pending=0, starve_cnt=0, pipe_hold=0. While reset is asserted, rf_we=0, md_ready=0 and stall=0.
- Arbitration is combinational with 0-cycle latency; the register file commits on the following rising edge.
  - pipe_hold=0: WB has priority. If wb_valid, grant WB and set md_ready=0. Otherwise md_ready=md_valid and grant MUL/DIV.
  - pipe_hold=1: grant MUL/DIV when md_valid. WB is ignored; the pipeline re-presents it next cycle.
- Write-port outputs:
  - rf_rd and rf_wdata come from the granted source.
  - rf_we=1 only when a grant occurs and the granted rd != 0.
  - A MUL/DIV result to x0 is still accepted (md_ready=1) but is not written.
- Scoreboard:
  - On md_issue with md_issue_rd != 0: set busy[md_issue_rd] and increment pending.
  - On MUL/DIV accept (md_valid && md_ready): clear busy[md_rd] and decrement pending.
  - Issue and accept in the same cycle: pending is unchanged. If both target the same rd, set wins.
  - busy[0] is always 0. An issue to x0 still increments pending, and the matching accept decrements it.
- stall is the OR of:
  - dec_rs1_used && busy[dec_rs1]
  - dec_rs2_used && busy[dec_rs2]
  - dec_rd_valid && busy[dec_rd] (WAW)
  - dec_is_md && pending==MAX_PENDING
- No bypass: a register completing this cycle still stalls its reader for this cycle.
- Starvation control:
  - starve_cnt increments each cycle md_valid && !md_ready, saturating at STARVE_LIMIT.
  - starve_cnt resets to 0 on accept or when md_valid=0.
  - pipe_hold is registered: it is set the cycle after starve_cnt reaches STARVE_LIMIT, lasts exactly one cycle, then starve_cnt=0.
- Protocol errors, flagged by simulation assertions only:
  - md_issue while stall=1.
  - pending overflow or underflow.
  - md_valid dropped before md_ready.
- Reset mid-operation: all scoreboard and hold state is cleared immediately. The in-flight MUL/DIV is expected to be reset by the same signal.

Test Plan:
- Reset: hold reset=0 with wb_valid=1, wb_rd=5 -> rf_we=0. Release reset; next cycle rf_we=1, rf_rd=5.
- Priority: wb_valid=1 (rd=3, data=0x11) and md_valid=1 (rd=4, data=0x22) in the same cycle -> rf_rd=3, md_ready=0. Next cycle wb_valid=0 -> rf_rd=4, rf_wdata=0x22, md_ready=1.
- Scoreboard: issue MUL to x10; decode rs1=10, dec_rs1_used=1 -> stall=1 until the cycle after x10 is accepted, then stall=0 and pending returns to 0.
- Capacity: issue to x6, then x7 (MAX_PENDING=2); decode dec_is_md=1 -> stall=1. Accept x6 -> pending=1 and stall drops the next cycle.
- Starvation: wb_valid=1 every cycle with md_valid=1 -> after 4 refused cycles pipe_hold=1 for one cycle, MUL/DIV written that cycle, pipe_hold=0 after.
- x0: issue MUL to x0; result arrives -> md_ready=1, rf_we=0, busy unchanged, pending 1->0.
